conv3x3_stream_layer: RTL and testbench
=======================================

Name: conv3x3_stream_layer

Overview:
Parametrised streaming 3x3 "valid" convolution layer with IN_CH input channels and OUT_CH filters. Weights are loaded at run time, not hard-wired. The output is requantised back to DATA_WIDTH so instances cascade directly, layer to layer. Valid/ready on input and output; a frame-level FSM replaces free-running window logic.

Parameters:
DATA_WIDTH, 8, pixel width in and out per channel
WT_WIDTH, 8, signed weight width
IN_CH, 3, input channels
OUT_CH, 4, filters (output channels)
IMG_W, 32, input frame width in pixels (>=3)
IMG_H, 32, input frame height in pixels (>=3)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse: begin a frame
wt_valid  in  1  weight word valid
wt_ready  out  1  weight word accepted when wt_valid&&wt_ready
wt_data  in  WT_WIDTH  signed weight word
cfg_shift  in  5  arithmetic right shift applied to accumulator; sampled at start
cfg_relu  in  1  1: unsigned ReLU output, 0: signed saturated output; sampled at start
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid&&s_ready
s_data  in  IN_CH*DATA_WIDTH  unsigned pixel, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_data  out  OUT_CH*DATA_WIDTH  filter f at bits [f*DATA_WIDTH +: DATA_WIDTH]
weights_loaded  out  1  full weight set present
busy  out  1  state is RUN or FLUSH
frame_done  out  1  one-cycle pulse after last output is accepted

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0, weights_loaded=0, m_valid=0, m_data=0, s_ready=0, wt_ready=0, busy=0, frame_done=0. Weight and line-buffer contents need not be cleared.
- States: IDLE, LOAD, RUN, FLUSH.
- IDLE:
  - wt_ready=1.
  - wt_valid -> LOAD. The word is stored, the count is set to 1, and weights_loaded is cleared.
  - start with weights_loaded=1 -> RUN. cfg_shift/cfg_relu are latched, and row/col counters are cleared.
  - If start and wt_valid occur in the same cycle, the weight wins and start is ignored.
  - start with weights_loaded=0 is ignored.
- LOAD:
  - wt_ready=1. Words arrive in order filter f, then channel c, then tap k = 3*row+col (row 0 = oldest line). Total N = OUT_CH*IN_CH*9 words.
  - On acceptance of word N: weights_loaded=1, -> IDLE.
  - start is ignored in LOAD.
- RUN:
  - wt_ready=0. Pixels arrive raster order, row-major.
  - Two line buffers of IMG_W entries per channel plus a 3x3 shift window per channel.
  - A window is valid when the accepted pixel has row>=2 and col>=2; no padding. Output frame is (IMG_W-2)x(IMG_H-2).
  - After IMG_W*IMG_H pixels are accepted -> FLUSH.
- FLUSH:
  - s_ready=0.
  - When the pipeline is empty and the last m_valid is accepted: frame_done=1 for one cycle, -> IDLE.
  - weights_loaded stays 1.
- Pipeline: two stages (S1 MAC register, S2 requantise register = m_data/m_valid). Global advance en = !m_valid || m_ready; both stages move only on en.
  - s_ready = (state==RUN) && en.
  - Latency: accept of the window-completing pixel -> m_valid two cycles later when unstalled.
  - While m_valid && !m_ready, m_data holds stable and no input is accepted.
- Arithmetic:
  - Pixel is zero-extended, weight is signed.
  - Per filter, acc = sum over c,k of pixel*weight.
  - ACC_W = DATA_WIDTH+WT_WIDTH+clog2(9*IN_CH)+1, signed; no overflow possible.
  - q = acc >>> cfg_shift (arithmetic).
  - cfg_relu=1: q<0 -> 0; q>2^DATA_WIDTH-1 -> 2^DATA_WIDTH-1.
  - cfg_relu=0: saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], two's complement.
- Boundaries:
  - Column counter wraps at IMG_W-1 and increments row.
  - Line buffer address wraps with the column counter.
  - A start pulse during RUN/FLUSH is ignored.
  - Reset mid-frame or mid-load aborts; weights_loaded=0, so weights must be reloaded.

Decomposition:
- Shared package: state encoding, ACC_W function, clog2 function, saturate/requantise function, weight index function idx(f,c,k).
- One natural sub-module: conv_window_buffer (per-channel 2-line buffer + 3x3 window, accepts shift enable, outputs 9 taps and window_valid).
- MAC tree and requantise stay in the top module.

Test Plan:
- Params IMG_W=5, IMG_H=4, IN_CH=3, OUT_CH=4; all weights 1; all pixels 1; shift 0; relu=1 -> exactly 6 outputs, every lane 27, then one frame_done pulse.
- Filter 0: centre tap of channel 0 = 1, rest 0; pixel = raster index -> filter 0 outputs 6,7,8,11,12,13.
- All weights -1, pixels 255: relu=1 gives 0; relu=0 with shift 0 gives -128 (0x80); relu=0 with shift 8 gives -27 (0xE5).
- Random m_ready (50%) with random s_valid -> output sequence identical to the unstalled run, m_data stable while stalled, no pixel lost or duplicated.
- start during LOAD (partial weights), and start in the same cycle as wt_valid in IDLE -> no RUN entry, busy stays 0.
- Assert rst low mid-RUN -> m_valid=0, weights_loaded=0 immediately; after reload and start, the full frame is correct.

Source files
------------

// File: rtl/conv3x3_stream_layer_pkg.sv
// Shared types and helpers for the streaming 3x3 convolution layer:
// FSM encoding, accumulator sizing, weight indexing and requantisation.
package conv3x3_stream_layer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   localparam int TAPS = 9;

   // Ceiling log2, never below 1 so it can size a counter directly.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int acc_w_f(input int dw, input int ww, input int in_ch);
      return dw + ww + clog2_f(TAPS * in_ch) + 1;
   endfunction

   // Weight words arrive filter-major, then channel, then tap.
   function automatic int idx_f(input int f, input int c, input int k, input int in_ch);
      return (f * in_ch + c) * TAPS + k;
   endfunction

   function automatic longint requant_f(input longint acc, input logic [4:0] shift,
                                        input logic relu, input int dw);
      longint q;
      longint lo;
      longint hi;
      q = acc >>> shift;
      if (relu) begin
         lo = 0;
         hi = (longint'(1) << dw) - 1;
      end else begin
         lo = -(longint'(1) << (dw - 1));
         hi = (longint'(1) << (dw - 1)) - 1;
      end
      if (q < lo) q = lo;
      else if (q > hi) q = hi;
      return q;
   endfunction

endpackage

// File: rtl/conv3x3_stream_layer_window.sv
// Two line buffers plus a 3x3 shift window per channel, with the raster
// row/column counters that decide when a complete window is present.
module conv_window_buffer
   import conv3x3_stream_layer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IN_CH      = 3,
   parameter int IMG_W      = 32,
   parameter int IMG_H      = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic                                adv,
   input  logic                                shift_en,
   input  logic [IN_CH*DATA_WIDTH-1:0]         pix_in,
   output logic [IN_CH*TAPS*DATA_WIDTH-1:0]    taps,
   output logic                                window_valid,
   output logic                                last_pix
);

   localparam int COL_W = clog2_f(IMG_W);
   localparam int ROW_W = clog2_f(IMG_H + 1);

   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic                  wv_q, wv_d;
   logic                  win_ok;
   logic [DATA_WIDTH-1:0] lb0_q [IN_CH][IMG_W];
   logic [DATA_WIDTH-1:0] lb1_q [IN_CH][IMG_W];
   logic [DATA_WIDTH-1:0] win_q [IN_CH][TAPS];

   assign win_ok       = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
   assign last_pix     = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
   assign window_valid = wv_q;

   // The valid flag is a token: it is consumed whenever the pipeline advances.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      wv_d  = wv_q;
      if (clear) begin
         col_d = '0;
         row_d = '0;
         wv_d  = 1'b0;
      end else begin
         if (shift_en) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         if (adv) wv_d = shift_en && win_ok;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= '0;
         row_q <= '0;
         wv_q  <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         wv_q  <= wv_d;
      end
   end

   // lb0 holds the oldest line, lb1 the previous one; window row 0 is oldest.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         for (int c = 0; c < IN_CH; c++) begin
            lb0_q[c][col_q] <= lb1_q[c][col_q];
            lb1_q[c][col_q] <= pix_in[c*DATA_WIDTH +: DATA_WIDTH];
            for (int r = 0; r < 3; r++) begin
               win_q[c][3*r]   <= win_q[c][3*r+1];
               win_q[c][3*r+1] <= win_q[c][3*r+2];
            end
            win_q[c][2] <= lb0_q[c][col_q];
            win_q[c][5] <= lb1_q[c][col_q];
            win_q[c][8] <= pix_in[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      taps = '0;
      for (int c = 0; c < IN_CH; c++) begin
         for (int k = 0; k < TAPS; k++) begin
            taps[(c*TAPS+k)*DATA_WIDTH +: DATA_WIDTH] = win_q[c][k];
         end
      end
   end

endmodule

// File: rtl/conv3x3_stream_layer.sv
// Streaming 3x3 valid convolution with run-time weights, a frame FSM and a
// two-stage MAC/requantise pipeline whose output width matches its input.
module conv3x3_stream_layer
   import conv3x3_stream_layer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int WT_WIDTH   = 8,
   parameter int IN_CH      = 3,
   parameter int OUT_CH     = 4,
   parameter int IMG_W      = 32,
   parameter int IMG_H      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          wt_valid,
   output logic                          wt_ready,
   input  logic signed [WT_WIDTH-1:0]    wt_data,
   input  logic [4:0]                    cfg_shift,
   input  logic                          cfg_relu,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [IN_CH*DATA_WIDTH-1:0]   s_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [OUT_CH*DATA_WIDTH-1:0]  m_data,
   output logic                          weights_loaded,
   output logic                          busy,
   output logic                          frame_done,
   output logic [1:0]                    dbg_state
);

   localparam int N_WT  = OUT_CH * IN_CH * TAPS;
   localparam int WA    = clog2_f(N_WT);
   localparam int ACC_W = acc_w_f(DATA_WIDTH, WT_WIDTH, IN_CH);

   state_e                     state_q, state_d;
   logic [WA-1:0]              wt_cnt_q, wt_cnt_d;
   logic                       wl_q, wl_d;
   logic                       wt_ready_q, wt_ready_d;
   logic [4:0]                 shift_q, shift_d;
   logic                       relu_q, relu_d;
   logic                       frame_done_q, frame_done_d;
   logic                       s1_valid_q;
   logic signed [ACC_W-1:0]    acc_q [OUT_CH];
   logic signed [ACC_W-1:0]    acc_d [OUT_CH];
   logic                       m_valid_q;
   logic [OUT_CH*DATA_WIDTH-1:0] m_data_q, m_data_d;

   logic signed [WT_WIDTH-1:0] wt_mem_q [N_WT];
   logic                       wt_we;
   logic [WA-1:0]              wt_addr;
   logic                       clear;
   logic                       en;
   logic                       s_acc;
   logic                       wt_acc;
   logic                       win_valid;
   logic                       last_pix;
   logic [IN_CH*TAPS*DATA_WIDTH-1:0] taps;

   // Handshakes: a word/pixel transfers on a rising edge where valid && ready;
   // valid must hold with stable data until then. Both pipeline stages move
   // together only when the output register is empty or being drained.
   assign en      = !m_valid_q || m_ready;
   assign s_ready = (state_q == ST_RUN) && en;
   assign s_acc   = s_valid && s_ready;
   assign wt_acc  = wt_valid && wt_ready_q;

   assign wt_ready       = wt_ready_q;
   assign m_valid        = m_valid_q;
   assign m_data         = m_data_q;
   assign weights_loaded = wl_q;
   assign busy           = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign frame_done     = frame_done_q;
   assign dbg_state      = state_q;

   conv_window_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .IN_CH      (IN_CH),
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H)
   ) u_window (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .adv          (en),
      .shift_en     (s_acc),
      .pix_in       (s_data),
      .taps         (taps),
      .window_valid (win_valid),
      .last_pix     (last_pix)
   );

   always_comb begin
      state_d      = state_q;
      wt_cnt_d     = wt_cnt_q;
      wl_d         = wl_q;
      shift_d      = shift_q;
      relu_d       = relu_q;
      frame_done_d = 1'b0;
      clear        = 1'b0;
      wt_we        = 1'b0;
      wt_addr      = wt_cnt_q;
      case (state_q)
         ST_IDLE: begin
            // A weight word takes priority over a simultaneous start.
            if (wt_acc) begin
               wt_we    = 1'b1;
               wt_addr  = '0;
               wt_cnt_d = WA'(1);
               wl_d     = 1'b0;
               state_d  = ST_LOAD;
            end else if (start && wl_q && !wt_valid) begin
               shift_d = cfg_shift;
               relu_d  = cfg_relu;
               clear   = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_LOAD: begin
            if (wt_acc) begin
               wt_we = 1'b1;
               if (wt_cnt_q == WA'(N_WT - 1)) begin
                  wt_cnt_d = '0;
                  wl_d     = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  wt_cnt_d = wt_cnt_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (s_acc && last_pix) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (!win_valid && !s1_valid_q && m_valid_q && m_ready) begin
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      wt_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
   end

   always_comb begin
      for (int f = 0; f < OUT_CH; f++) begin
         acc_d[f] = '0;
         for (int c = 0; c < IN_CH; c++) begin
            for (int k = 0; k < TAPS; k++) begin
               acc_d[f] = acc_d[f]
                  + ACC_W'($signed({1'b0, taps[(c*TAPS+k)*DATA_WIDTH +: DATA_WIDTH]}))
                  * ACC_W'(wt_mem_q[idx_f(f, c, k, IN_CH)]);
            end
         end
      end
   end

   always_comb begin
      m_data_d = '0;
      for (int f = 0; f < OUT_CH; f++) begin
         m_data_d[f*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(requant_f(longint'(acc_q[f]), shift_q, relu_q, DATA_WIDTH));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         wt_cnt_q     <= '0;
         wl_q         <= 1'b0;
         wt_ready_q   <= 1'b0;
         shift_q      <= '0;
         relu_q       <= 1'b0;
         frame_done_q <= 1'b0;
         s1_valid_q   <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         for (int f = 0; f < OUT_CH; f++) acc_q[f] <= '0;
      end else begin
         state_q      <= state_d;
         wt_cnt_q     <= wt_cnt_d;
         wl_q         <= wl_d;
         wt_ready_q   <= wt_ready_d;
         shift_q      <= shift_d;
         relu_q       <= relu_d;
         frame_done_q <= frame_done_d;
         if (en) begin
            s1_valid_q <= win_valid;
            m_valid_q  <= s1_valid_q;
            m_data_q   <= m_data_d;
            for (int f = 0; f < OUT_CH; f++) acc_q[f] <= acc_d[f];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wt_we) wt_mem_q[wt_addr] <= wt_data;
   end

endmodule

// File: tb/tb_conv3x3_stream_layer.sv
// Directed bench for conv3x3_stream_layer on a 5x4 frame, 3 in / 4 out channels.
module tb_conv3x3_stream_layer;

   localparam int DW  = 8;
   localparam int WW  = 8;
   localparam int IC  = 3;
   localparam int OC  = 4;
   localparam int IW  = 5;
   localparam int IH  = 4;
   localparam int NWT = OC * IC * 9;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic                 wt_valid;
   logic                 wt_ready;
   logic signed [WW-1:0] wt_data;
   logic [4:0]           cfg_shift;
   logic                 cfg_relu;
   logic                 s_valid;
   logic                 s_ready;
   logic [IC*DW-1:0]     s_data;
   logic                 m_valid;
   logic                 m_ready;
   logic [OC*DW-1:0]     m_data;
   logic                 weights_loaded;
   logic                 busy;
   logic                 frame_done;
   logic [1:0]           dbg_state;

   int          checks = 0;
   int          failures = 0;
   int          out_cnt = 0;
   int          done_cnt = 0;
   bit          stall_mode = 0;
   bit          held_valid = 0;
   logic [31:0] held_data;
   logic [31:0] exp_q[$];

   conv3x3_stream_layer #(
      .DATA_WIDTH (DW),
      .WT_WIDTH   (WW),
      .IN_CH      (IC),
      .OUT_CH     (OC),
      .IMG_W      (IW),
      .IMG_H      (IH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .wt_valid       (wt_valid),
      .wt_ready       (wt_ready),
      .wt_data        (wt_data),
      .cfg_shift      (cfg_shift),
      .cfg_relu       (cfg_relu),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .weights_loaded (weights_loaded),
      .busy           (busy),
      .frame_done     (frame_done),
      .dbg_state      (dbg_state)
   );

   // Clock and downstream ready
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      m_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: outputs are taken in order from exp_q; held outputs must not move.
   always @(negedge clk) begin
      logic [31:0] exp_v;
      if (!rst) begin
         held_valid = 0;
      end else begin
         if (held_valid) begin
            check_eq("m_valid_hold", 32'(m_valid), 32'd1);
            check_eq("m_data_hold", m_data, held_data);
         end
         if (frame_done) done_cnt++;
         if (m_valid && m_ready) begin
            if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            else exp_v = ~m_data;
            check_eq("m_data", m_data, exp_v);
            out_cnt++;
            held_valid = 0;
         end else if (m_valid) begin
            held_valid = 1;
            held_data  = m_data;
         end else begin
            held_valid = 0;
         end
      end
   end

   // Drivers
   function automatic logic [WW-1:0] wval(input int kind, input int i);
      case (kind)
         0:       return 8'h01;
         1:       return 8'hFF;
         default: return (i == 4) ? 8'h01 : 8'h00;
      endcase
   endfunction

   function automatic logic [IC*DW-1:0] pixv(input int kind, input int p);
      logic [7:0] b;
      b = 8'(p);
      case (kind)
         0:       return {3{8'h01}};
         1:       return {3{8'hFF}};
         default: return {3{b}};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_words(input int kind, input int from, input int to);
      int n;
      bit hs;
      for (int i = from; i <= to; i++) begin
         wt_valid = 1'b1;
         wt_data  = wval(kind, i);
         n  = 0;
         hs = 0;
         while (!hs && n < 50) begin
            @(negedge clk);
            hs = wt_ready;
            tick();
            n++;
         end
         if (!hs) check_eq("wt_timeout", 32'(hs), 32'd1);
      end
      wt_valid = 1'b0;
   endtask

   task automatic send_pixel(input logic [IC*DW-1:0] d, input bit gaps);
      int n;
      bit hs;
      if (gaps) begin
         s_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      s_valid = 1'b1;
      s_data  = d;
      n  = 0;
      hs = 0;
      while (!hs && n < 200) begin
         @(negedge clk);
         hs = s_ready;
         tick();
         n++;
      end
      if (!hs) check_eq("pix_timeout", 32'(hs), 32'd1);
      s_valid = 1'b0;
   endtask

   task automatic push_const(input logic [31:0] v);
      repeat (6) exp_q.push_back(v);
   endtask

   task automatic push_centre();
      int centre [6] = '{6, 7, 8, 11, 12, 13};
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(centre[i]));
   endtask

   task automatic run_frame(input logic [4:0] sh, input logic rl, input int kind, input bit gaps);
      int ob;
      int db;
      int n;
      ob = out_cnt;
      db = done_cnt;
      cfg_shift = sh;
      cfg_relu  = rl;
      pulse_start();
      check_eq("busy_run", 32'(busy), 32'd1);
      for (int p = 0; p < IW * IH; p++) send_pixel(pixv(kind, p), gaps);
      n = 0;
      while (done_cnt == db && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      tick();
      check_eq("frame_done_cnt", 32'(done_cnt - db), 32'd1);
      check_eq("out_cnt", 32'(out_cnt - ob), 32'd6);
      check_eq("exp_q_left", 32'(exp_q.size()), 32'd0);
      check_eq("busy_idle", 32'(busy), 32'd0);
      check_eq("wl_kept", 32'(weights_loaded), 32'd1);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      wt_valid  = 1'b0;
      wt_data   = '0;
      cfg_shift = '0;
      cfg_relu  = 1'b0;
      s_valid   = 1'b0;
      s_data    = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_m_data", m_data, 32'd0);
      check_eq("rst_s_ready", 32'(s_ready), 32'd0);
      check_eq("rst_wt_ready", 32'(wt_ready), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_frame_done", 32'(frame_done), 32'd0);
      check_eq("rst_wl", 32'(weights_loaded), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b1;
      tick();
      check_eq("idle_wt_ready", 32'(wt_ready), 32'd1);

      // start without weights is ignored
      pulse_start();
      check_eq("nowt_busy", 32'(busy), 32'd0);
      check_eq("nowt_state", 32'(dbg_state), 32'd0);

      // all weights 1, pixels 1 -> 27 per lane
      load_words(0, 0, NWT - 1);
      check_eq("wl_set", 32'(weights_loaded), 32'd1);
      push_const(32'h1B1B_1B1B);
      run_frame(5'd0, 1'b1, 0, 0);

      // all weights -1, pixels 255 -> acc -6885
      load_words(1, 0, NWT - 1);
      push_const(32'h0000_0000);
      run_frame(5'd0, 1'b1, 1, 0);
      push_const(32'h8080_8080);
      run_frame(5'd0, 1'b0, 1, 0);
      push_const(32'hE5E5_E5E5);
      run_frame(5'd8, 1'b0, 1, 0);

      // start together with a weight word: the weight wins
      start    = 1'b1;
      wt_valid = 1'b1;
      wt_data  = wval(2, 0);
      tick();
      start    = 1'b0;
      wt_valid = 1'b0;
      check_eq("race_busy", 32'(busy), 32'd0);
      check_eq("race_wl", 32'(weights_loaded), 32'd0);
      check_eq("race_state", 32'(dbg_state), 32'd1);
      load_words(2, 1, 9);
      pulse_start();
      check_eq("load_start_busy", 32'(busy), 32'd0);
      check_eq("load_start_state", 32'(dbg_state), 32'd1);
      load_words(2, 10, NWT - 1);
      check_eq("reload_wl", 32'(weights_loaded), 32'd1);
      check_eq("reload_state", 32'(dbg_state), 32'd0);

      // centre tap of channel 0 on filter 0, raster-index pixels
      push_centre();
      run_frame(5'd0, 1'b1, 2, 0);

      // same frame with random backpressure and input gaps
      stall_mode = 1;
      push_centre();
      run_frame(5'd0, 1'b1, 2, 1);
      stall_mode = 0;

      // reset in the middle of a frame
      push_centre();
      cfg_shift = 5'd0;
      cfg_relu  = 1'b1;
      pulse_start();
      for (int p = 0; p < 14; p++) send_pixel(pixv(2, p), 0);
      #2;
      rst = 1'b0;
      #1;
      check_eq("abort_m_valid", 32'(m_valid), 32'd0);
      check_eq("abort_wl", 32'(weights_loaded), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_s_ready", 32'(s_ready), 32'd0);
      tick();
      rst = 1'b1;
      exp_q.delete();
      tick();
      load_words(2, 0, NWT - 1);
      push_centre();
      run_frame(5'd0, 1'b1, 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
